// File: rtl/uart_tx_os16.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_os16
// Brief    : Oversampled UART transmitter; one-entry holding register feeds a
//            start/data/parity/stop shifter advanced only on os_tick.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_os16 #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 os_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_line,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int c_cnt_w = $clog2(OVERSAMPLE) + 1;
   localparam int c_idx_w = $clog2(DATA_BITS + 1);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_start  = 3'd1;
   localparam logic [2:0] c_st_data   = 3'd2;
   localparam logic [2:0] c_st_parity = 3'd3;
   localparam logic [2:0] c_st_stop   = 3'd4;

   localparam logic [c_cnt_w-1:0] c_os_last    = c_cnt_w'(OVERSAMPLE - 1);
   localparam logic [c_idx_w-1:0] c_data_last  = c_idx_w'(DATA_BITS - 1);
   localparam logic [c_idx_w-1:0] c_stop_last  = c_idx_w'(STOP_BITS - 1);
   localparam logic               c_parity_inv = (PARITY_ODD != 0);

   logic [2:0]           state_q,     state_d;
   logic [c_cnt_w-1:0]   os_cnt_q,    os_cnt_d;
   logic [c_idx_w-1:0]   bit_idx_q,   bit_idx_d;
   logic [DATA_BITS-1:0] shifter_q,   shifter_d;
   logic [DATA_BITS-1:0] hold_q,      hold_d;
   logic                 hold_full_q, hold_full_d;
   logic                 parity_q,    parity_d;
   logic                 tx_line_q,   tx_line_d;
   logic                 tx_done_q,   tx_done_d;
   logic                 tx_ready_q,  tx_ready_d;

   logic                 w_accept;
   logic                 w_load;
   logic                 w_bit_end;

   // State register; reset wins over any accept or tick on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= c_st_idle;
         os_cnt_q    <= '0;
         bit_idx_q   <= '0;
         shifter_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         parity_q    <= 1'b0;
         tx_line_q   <= 1'b1;
         tx_done_q   <= 1'b0;
         tx_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         os_cnt_q    <= os_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shifter_q   <= shifter_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         parity_q    <= parity_d;
         tx_line_q   <= tx_line_d;
         tx_done_q   <= tx_done_d;
         tx_ready_q  <= tx_ready_d;
      end
   end

   // Next-state and datapath logic.
   always_comb begin
      state_d     = state_q;
      os_cnt_d    = os_cnt_q;
      bit_idx_d   = bit_idx_q;
      shifter_d   = shifter_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      parity_d    = parity_q;
      tx_line_d   = tx_line_q;
      tx_done_d   = 1'b0;
      w_load      = 1'b0;
      w_bit_end   = (os_cnt_q == c_os_last);
      // tx_ready_q mirrors !hold_full_q, so accept and load are exclusive.
      w_accept    = tx_valid && tx_ready_q;

      if (w_accept) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      if (os_tick) begin
         if (state_q != c_st_idle) begin
            os_cnt_d = w_bit_end ? '0 : os_cnt_q + 1'b1;
         end

         case (state_q)
            c_st_idle: begin
               w_load = hold_full_q;
            end
            c_st_start: begin
               if (w_bit_end) begin
                  state_d   = c_st_data;
                  bit_idx_d = '0;
                  tx_line_d = shifter_q[0];
               end
            end
            c_st_data: begin
               if (w_bit_end) begin
                  if (bit_idx_q == c_data_last) begin
                     if (PARITY_EN != 0) begin
                        state_d   = c_st_parity;
                        tx_line_d = parity_q;
                     end else begin
                        state_d   = c_st_stop;
                        bit_idx_d = '0;
                        tx_line_d = 1'b1;
                     end
                  end else begin
                     bit_idx_d = bit_idx_q + 1'b1;
                     shifter_d = shifter_q >> 1;
                     tx_line_d = shifter_q[1];
                  end
               end
            end
            c_st_parity: begin
               if (w_bit_end) begin
                  state_d   = c_st_stop;
                  bit_idx_d = '0;
                  tx_line_d = 1'b1;
               end
            end
            c_st_stop: begin
               if (w_bit_end) begin
                  if (bit_idx_q == c_stop_last) begin
                     tx_done_d = 1'b1;
                     if (hold_full_q) begin
                        w_load = 1'b1;
                     end else begin
                        state_d   = c_st_idle;
                        bit_idx_d = '0;
                        tx_line_d = 1'b1;
                     end
                  end else begin
                     bit_idx_d = bit_idx_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d   = c_st_idle;
               os_cnt_d  = '0;
               bit_idx_d = '0;
               tx_line_d = 1'b1;
            end
         endcase

         // Shared by idle start and back-to-back start at end of stop.
         if (w_load) begin
            state_d     = c_st_start;
            tx_line_d   = 1'b0;
            shifter_d   = hold_q;
            hold_full_d = 1'b0;
            os_cnt_d    = '0;
            bit_idx_d   = '0;
            parity_d    = (^hold_q) ^ c_parity_inv;
         end
      end

      tx_ready_d = ~hold_full_d;
   end

   // Outputs come straight from registers except busy, a state decode.
   always_comb begin
      tx_ready = tx_ready_q;
      tx_line  = tx_line_q;
      tx_done  = tx_done_q;
      busy     = (state_q != c_st_idle);
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_os16.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_os16
// Brief    : Scoreboard bench for uart_tx_os16 over four parameter sets.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_os16;

   localparam int c_os = 16;

   typedef struct {
      logic [7:0] d;
      int         acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       os_tick;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic [1:0] sel;

   logic [3:0] valid_v, ready_v, line_v, busy_v, done_v;
   logic       w_line, w_ready, w_busy, w_done;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   tick_div;
   bit   tick_rand;
   exp_t q[$];

   int         mk;
   bit         mact;
   logic [7:0] md;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign valid_v = tx_valid ? (4'b0001 << sel) : 4'b0000;
   assign w_line  = line_v[sel];
   assign w_ready = ready_v[sel];
   assign w_busy  = busy_v[sel];
   assign w_done  = done_v[sel];

   uart_tx_os16 #(.DATA_BITS(8), .OVERSAMPLE(c_os), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .rst(rst), .os_tick(os_tick), .tx_data(tx_data), .tx_valid(valid_v[0]),
      .tx_ready(ready_v[0]), .tx_line(line_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
   uart_tx_os16 #(.DATA_BITS(8), .OVERSAMPLE(c_os), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .rst(rst), .os_tick(os_tick), .tx_data(tx_data), .tx_valid(valid_v[1]),
      .tx_ready(ready_v[1]), .tx_line(line_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
   uart_tx_os16 #(.DATA_BITS(8), .OVERSAMPLE(c_os), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
      .clk(clk), .rst(rst), .os_tick(os_tick), .tx_data(tx_data), .tx_valid(valid_v[2]),
      .tx_ready(ready_v[2]), .tx_line(line_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
   uart_tx_os16 #(.DATA_BITS(8), .OVERSAMPLE(c_os), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
      .clk(clk), .rst(rst), .os_tick(os_tick), .tx_data(tx_data), .tx_valid(valid_v[3]),
      .tx_ready(ready_v[3]), .tx_line(line_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

   // Frame length in bit periods for the selected configuration.
   function automatic int frame_bits(input logic [1:0] s);
      return 1 + 8 + ((s == 2'd1 || s == 2'd2) ? 1 : 0) + ((s == 2'd3) ? 2 : 1);
   endfunction

   // Expected line level during bit period b of a frame carrying d.
   function automatic logic exp_level(input logic [1:0] s, input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if ((s == 2'd1 || s == 2'd2) && b == 9) return (^d) ^ (s == 2'd2);
      return 1'b1;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d sel=%0d t=%0t", nm, act, exp, sel, $time);
      end
   endtask

   // Tick generator: periodic with tick_div, or random when tick_rand is set.
   initial begin
      int tcnt;
      tcnt    = 0;
      os_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_rand) os_tick = 1'($urandom_range(0, 1));
         else           os_tick = ((tcnt % tick_div) == 0);
         tcnt++;
      end
   end

   // Monitor: walks the expected frame tick by tick, independent of DUT progress.
   initial begin
      logic tk, rs, prev_ln;
      bit   seen_rst;
      seen_rst = 0;
      mact     = 0;
      mk       = 0;
      md       = '0;
      prev_ln  = 1'b1;
      forever begin
         @(posedge clk);
         tk = os_tick;
         rs = rst;
         #1;
         if (rs) begin
            seen_rst = 1;
            mact     = 0;
            mk       = 0;
            q.delete();
            chk("rst_line", int'(w_line), 1);
            chk("rst_ready", int'(w_ready), 1);
            chk("rst_busy", int'(w_busy), 0);
            chk("rst_done", int'(w_done), 0);
            prev_ln = w_line;
            continue;
         end
         if (!seen_rst) continue;
         if (tk) begin
            if (mact) begin
               mk++;
               if (mk == frame_bits(sel) * c_os) begin
                  chk("done_at_end", int'(w_done), 1);
                  mact = 0;
               end else begin
                  chk("done_in_frame", int'(w_done), 0);
                  chk("line_bit", int'(w_line), int'(exp_level(sel, md, mk / c_os)));
               end
            end else begin
               chk("done_idle", int'(w_done), 0);
            end
            if (!mact) begin
               if (q.size() > 0 && q[0].acc < cyc) begin
                  md = q[0].d;
                  q.pop_front();
                  mact = 1;
                  mk   = 0;
                  chk("line_start", int'(w_line), 0);
               end else begin
                  chk("line_idle", int'(w_line), 1);
               end
            end
         end else begin
            chk("line_hold", int'(w_line), int'(prev_ln));
            chk("done_notick", int'(w_done), 0);
         end
         chk("busy", int'(w_busy), int'(mact));
         chk("ready", int'(w_ready), (q.size() == 0) ? 1 : 0);
         prev_ln = w_line;
      end
   end

   // Offer a byte; the expected frame is queued for the edge that accepts it.
   task automatic send(input logic [7:0] d);
      int   n;
      exp_t e;
      n        = 0;
      tx_valid = 1'b1;
      tx_data  = d;
      while (!w_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!w_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=busy expected=ready data=%02h", d);
         tx_valid = 1'b0;
         return;
      end
      e.d   = d;
      e.acc = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || mact) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=active expected=idle");
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      tx_valid  = 1'b0;
      tx_data   = '0;
      sel       = 2'd0;
      tick_div  = 1;
      tick_rand = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      send(8'h55);
      wait_idle();

      send(8'hA5);
      send(8'h3C);
      wait_idle();

      sel = 2'd1;
      send(8'h07);
      wait_idle();
      sel = 2'd2;
      send(8'h07);
      wait_idle();

      sel = 2'd3;
      send(8'h00);
      wait_idle();

      sel      = 2'd0;
      tick_div = 4;
      send(8'hFF);
      wait_idle();

      // Abort a frame mid-flight with a second byte sitting in the holding register.
      tick_div = 1;
      send(8'h0F);
      send(8'h5A);
      n = 0;
      while (mk < 50 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);

      // Requests made while reset is asserted must be dropped.
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h99;
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      tx_valid = 1'b0;
      repeat (50) @(negedge clk);

      for (int r = 0; r < 8; r++) begin
         wait_idle();
         sel       = 2'(r % 4);
         tick_rand = ($urandom_range(0, 1) == 1);
         tick_div  = $urandom_range(1, 3);
         for (int f = 0; f < 5; f++) begin
            send(8'($urandom));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 400)) @(negedge clk);
         end
      end
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_os16.md
UART_TX_OS16 -- requirements
Module: uart_tx_os16

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (5..9).
REQ-002 Parameter OVERSAMPLE, default 16, os_tick pulses per bit period (>=2).
REQ-003 Parameter PARITY_EN, default 0, 1 = insert parity bit after data.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1, stop bit count (1 or 2).
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 os_tick  input  1  one-cycle enable pulse at BAUD*OVERSAMPLE.
REQ-009 tx_data  input  DATA_BITS  byte to transmit, sampled on accept.
REQ-010 tx_valid  input  1  tx_data valid request.
REQ-011 tx_ready  output  1  holding register empty; accept occurs when tx_valid && tx_ready at a clk edge.
REQ-012 tx_line  output  1  serial line, idle high, registered.
REQ-013 busy  output  1  high while a frame is on the line (state != IDLE).
REQ-014 tx_done  output  1  one-clk pulse when the final stop bit period completes.

Function
REQ-015 One-entry holding register; tx_ready SHALL equal NOT hold_full, driven from a register, no combinational path from tx_valid.
REQ-016 Accept SHALL set hold_full and capture tx_data on that clk edge, independent of os_tick.
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY visited only when PARITY_EN=1.
REQ-018 All state, counter and tx_line updates except accept SHALL occur only on cycles with os_tick=1; tx_line holds otherwise.
REQ-019 IDLE: on os_tick with hold_full=1 -> START, tx_line<=0, shifter<=hold data, hold_full<=0, os_cnt<=0, parity computed from hold data.
REQ-020 Within any bit state: on os_tick, os_cnt==OVERSAMPLE-1 -> advance to next bit, os_cnt<=0; else os_cnt<=os_cnt+1; each bit thus lasts exactly OVERSAMPLE os_ticks.
REQ-021 DATA: bits sent LSB first; bit_idx 0..DATA_BITS-1; after bit DATA_BITS-1 -> PARITY (if enabled) else STOP.
REQ-022 Parity bit SHALL equal XOR of data bits, inverted when PARITY_ODD=1.
REQ-023 STOP: tx_line=1 for STOP_BITS*OVERSAMPLE os_ticks.
REQ-024 End of STOP: tx_done<=1 for one clk; if hold_full=1 -> START on that same os_tick (back-to-back, zero idle gap, same actions as REQ-019); else -> IDLE, tx_line=1.
REQ-025 Accept and hold-to-shifter transfer cannot coincide (tx_ready=0 while hold_full=1); no overwrite of held data.
REQ-026 tx_data changes after accept SHALL NOT affect the frame.
REQ-027 os_cnt width $clog2(OVERSAMPLE)+1; bit_idx width sufficient for DATA_BITS; no wrap beyond limits.
REQ-028 Illegal state encodings SHALL return to IDLE with tx_line=1 on next os_tick.

Reset
REQ-029 rst=1 SHALL, on the next clk edge regardless of os_tick: state=IDLE, tx_line=1, tx_ready=1, hold_full=0, busy=0, tx_done=0, os_cnt=0, bit_idx=0, shifter=0.
REQ-030 Reset mid-frame SHALL abort the frame and discard held data; no tx_done pulse.
REQ-031 Accept attempted while rst=1 SHALL be ignored.

Verification
REQ-032 Defaults, os_tick every cycle, send 0x55 -> tx_line low 16 ticks, then 1,0,1,0,1,0,1,0 each 16 ticks, high 16 ticks; tx_done at tick 160; busy low after.
REQ-033 Send 0xA5 then 0x3C offered while first frame active -> second start bit begins immediately after first stop bit, 320 ticks total, two tx_done pulses 160 ticks apart.
REQ-034 PARITY_EN=1 even, send 0x07 -> parity bit 1; PARITY_ODD=1, 0x07 -> parity bit 0; frame 176 ticks.
REQ-035 os_tick every 4th cycle, send 0xFF -> each bit lasts 64 clks; tx_line constant between ticks.
REQ-036 rst asserted at tick 50 of frame 0x0F with second byte held -> tx_line=1, tx_ready=1, busy=0 next clk; no tx_done; line stays high.
REQ-037 STOP_BITS=2, send 0x00 -> stop high for 32 ticks, tx_done at tick 176.
